// File: rtl/eeprom_config_loader.sv
// Boot-time sequencer: reads the board ID and config bytes from the I2C EEPROM byte-read engine,
// with per-byte timeout/retry, error reporting, periodic rescan of a blank EEPROM and manual reload.
module eeprom_config_loader #(
    parameter int          NUM_BYTES     = 4,
    parameter logic [10:0] BASE_ADDR     = 11'h000,
    parameter int          POWERUP_DELAY = 1_600_000,
    parameter int          TIMEOUT       = 160_000,
    parameter int          MAX_RETRIES   = 3,
    parameter int          RESCAN_PERIOD = 16_000_000,
    localparam int         IW            = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    output logic [10:0]   eeprom_addr,
    output logic          eeprom_read,
    input  logic [7:0]    eeprom_data,
    input  logic          eeprom_data_ready,
    output logic          cfg_we,
    output logic [IW-1:0] cfg_index,
    output logic [7:0]    cfg_data,
    output logic [7:0]    ID,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int CNT_MAX_A = (POWERUP_DELAY > TIMEOUT) ? POWERUP_DELAY : TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > RESCAN_PERIOD) ? CNT_MAX_A : RESCAN_PERIOD;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] PU_LAST   = CW'(POWERUP_DELAY - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RS_LAST   = CW'(RESCAN_PERIOD - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BYTES - 1);
    localparam logic [RW-1:0] RTY_ONE   = RW'(1);
    localparam logic [RW-1:0] RTY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_CHECK,
        ST_RESCAN,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    id_q, id_d;
    logic [IW-1:0] cfgIndex_q, cfgIndex_d;
    logic [7:0]    cfgData_q, cfgData_d;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q    <= ST_POWERUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            id_q       <= '0;
            cfgIndex_q <= '0;
            cfgData_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            id_q       <= id_d;
            cfgIndex_q <= cfgIndex_d;
            cfgData_q  <= cfgData_d;
        end
    end

    // The ISSUE cycle is timer tick 0 of an attempt, so read pulses of retries are TIMEOUT apart;
    // likewise the CHECK cycle is the first tick of a rescan period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        id_d       = id_q;
        cfgIndex_d = cfgIndex_q;
        cfgData_d  = cfgData_q;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q >= PU_LAST) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_ONE;
            end

            ST_WAIT: begin
                if (eeprom_data_ready) begin
                    state_d = ST_STORE;
                    cnt_d   = '0;
                    if (idx_q == '0) begin
                        id_d = eeprom_data;
                    end else begin
                        cfgIndex_d = idx_q;
                        cfgData_d  = eeprom_data;
                    end
                end else if (cnt_q >= TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RTY_MAX) begin
                        state_d = ST_ISSUE;
                        retry_d = retry_q + RTY_ONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STORE: begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_ISSUE;
                    idx_d   = idx_q + IDX_ONE;
                    retry_d = '0;
                end
            end

            ST_CHECK: begin
                if (id_q != 8'h00) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RESCAN;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_RESCAN: begin
                if (cnt_q >= RS_LAST) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE, ST_ERROR: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

    assign eeprom_addr = BASE_ADDR + 11'(idx_q);
    assign eeprom_read = (state_q == ST_ISSUE);
    assign cfg_we      = (state_q == ST_STORE) && (idx_q != '0);
    assign cfg_index   = cfgIndex_q;
    assign cfg_data    = cfgData_q;
    assign ID          = id_q;
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign busy        = (state_q != ST_DONE) && (state_q != ST_ERROR);

endmodule

// File: tb/tb_eeprom_config_loader.sv
// Directed bench for eeprom_config_loader with a cycle-stepped EEPROM responder model.
module tb_eeprom_config_loader;

    logic        CLK;
    logic        reset_n;
    logic        start;
    logic [10:0] eeprom_addr;
    logic        eeprom_read;
    logic [7:0]  eeprom_data;
    logic        eeprom_data_ready;
    logic        cfg_we;
    logic [1:0]  cfg_index;
    logic [7:0]  cfg_data;
    logic [7:0]  ID;
    logic        busy;
    logic        done;
    logic        error;

    eeprom_config_loader #(
        .NUM_BYTES     (4),
        .BASE_ADDR     (11'h000),
        .POWERUP_DELAY (10),
        .TIMEOUT       (8),
        .MAX_RETRIES   (3),
        .RESCAN_PERIOD (20)
    ) dut (
        .CLK               (CLK),
        .reset_n           (reset_n),
        .start             (start),
        .eeprom_addr       (eeprom_addr),
        .eeprom_read       (eeprom_read),
        .eeprom_data       (eeprom_data),
        .eeprom_data_ready (eeprom_data_ready),
        .cfg_we            (cfg_we),
        .cfg_index         (cfg_index),
        .cfg_data          (cfg_data),
        .ID                (ID),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int doneCyc = -1;

    logic [7:0] mem [4];
    int         silentN [4];
    int         attempts [4];
    int         respDelay = 3;
    bit         pendValid = 1'b0;
    int         pendAt = 0;
    logic [7:0] pendData = 8'h00;

    int         readCyc [$];
    int         readAddr [$];
    int         cfgCyc [$];
    int         cfgIdx [$];
    logic [7:0] cfgDat [$];

    task automatic clearLogs();
        readCyc.delete();
        readAddr.delete();
        cfgCyc.delete();
        cfgIdx.delete();
        cfgDat.delete();
        for (int i = 0; i < 4; i++) begin
            attempts[i] = 0;
            silentN[i]  = 0;
        end
        pendValid = 1'b0;
        doneCyc   = -1;
    endtask

    // One clock: observe outputs just after the edge, log events, drive the responder
    task automatic step();
        int a;
        @(posedge CLK);
        #1;
        cyc++;
        eeprom_data_ready = 1'b0;
        eeprom_data       = 8'h00;
        if (eeprom_read === 1'b1) begin
            a = int'(eeprom_addr);
            readCyc.push_back(cyc);
            readAddr.push_back(a);
            if (a < 4) begin
                attempts[a]++;
                if (attempts[a] > silentN[a]) begin
                    pendValid = 1'b1;
                    pendAt    = cyc + respDelay;
                    pendData  = mem[a];
                end
            end
        end
        if (cfg_we === 1'b1) begin
            cfgCyc.push_back(cyc);
            cfgIdx.push_back(int'(cfg_index));
            cfgDat.push_back(cfg_data);
        end
        if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
        if (pendValid && cyc == pendAt) begin
            eeprom_data_ready = 1'b1;
            eeprom_data       = pendData;
            pendValid         = 1'b0;
        end
    endtask

    task automatic runUntilIdle(input int budget, output bit ok);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            step();
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        eeprom_data_ready = 1'b0;
        eeprom_data = 8'h00;
        step();
        step();
        checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", error); else passes++;
        checks++; if (eeprom_read !== 1'b0) $display("[TB] FAIL reset_read: got %b expected 0", eeprom_read); else passes++;
        checks++; if (cfg_we !== 1'b0) $display("[TB] FAIL reset_cfg_we: got %b expected 0", cfg_we); else passes++;
        checks++; if (eeprom_addr !== 11'h000) $display("[TB] FAIL reset_addr: got %h expected 000", eeprom_addr); else passes++;
        checks++; if (ID !== 8'h00) $display("[TB] FAIL reset_id: got %h expected 00", ID); else passes++;
        checks++; if ({cfg_index, cfg_data} !== 10'h000) $display("[TB] FAIL reset_cfg: got %h/%h expected 0/00", cfg_index, cfg_data); else passes++;
        reset_n = 1'b1;
        cyc = 0;
        clearLogs();
    endtask

    task automatic test_basic_load();
        bit ok;
        logic [7:0] expDat [3];
        expDat = '{8'h11, 8'h22, 8'h33};
        mem = '{8'h2A, 8'h11, 8'h22, 8'h33};
        respDelay = 3;
        runUntilIdle(200, ok);
        checks++; if (!ok) $display("[TB] FAIL load_timeout: busy=%b expected 0 within budget", busy); else passes++;
        checks++; if (readCyc.size() != 4) $display("[TB] FAIL load_read_count: got %0d expected 4", readCyc.size()); else passes++;
        if (readCyc.size() > 0) begin
            checks++; if (readCyc[0] != 10) $display("[TB] FAIL load_first_read_cycle: got %0d expected 10", readCyc[0]); else passes++;
        end
        for (int i = 0; i < readAddr.size() && i < 4; i++) begin
            checks++; if (readAddr[i] != i) $display("[TB] FAIL load_addr%0d: got %0d expected %0d", i, readAddr[i], i); else passes++;
        end
        checks++; if (cfgIdx.size() != 3) $display("[TB] FAIL load_cfg_count: got %0d expected 3", cfgIdx.size()); else passes++;
        for (int i = 0; i < cfgIdx.size() && i < 3; i++) begin
            checks++; if (cfgIdx[i] != i + 1 || cfgDat[i] !== expDat[i]) $display("[TB] FAIL load_cfg%0d: got (%0d,%h) expected (%0d,%h)", i, cfgIdx[i], cfgDat[i], i + 1, expDat[i]); else passes++;
        end
        checks++; if (ID !== 8'h2A) $display("[TB] FAIL load_id: got %h expected 2a", ID); else passes++;
        checks++; if (done !== 1'b1 || error !== 1'b0) $display("[TB] FAIL load_flags: got done=%b error=%b expected 1/0", done, error); else passes++;
        checks++; if (doneCyc != 31) $display("[TB] FAIL load_done_cycle: got %0d expected 31", doneCyc); else passes++;
    endtask

    task automatic test_retry();
        bit ok;
        clearLogs();
        mem = '{8'h2A, 8'h44, 8'h55, 8'h66};
        silentN[1] = 2;
        pulseStart();
        runUntilIdle(300, ok);
        checks++; if (!ok) $display("[TB] FAIL retry_timeout: busy=%b expected 0 within budget", busy); else passes++;
        checks++; if (readAddr.size() != 6) $display("[TB] FAIL retry_read_count: got %0d expected 6", readAddr.size()); else passes++;
        if (readAddr.size() >= 4) begin
            checks++; if (readAddr[1] != 1 || readAddr[2] != 1 || readAddr[3] != 1) $display("[TB] FAIL retry_addrs: got %0d,%0d,%0d expected 1,1,1", readAddr[1], readAddr[2], readAddr[3]); else passes++;
            checks++; if (readCyc[2] - readCyc[1] != 8) $display("[TB] FAIL retry_gap1: got %0d expected 8", readCyc[2] - readCyc[1]); else passes++;
            checks++; if (readCyc[3] - readCyc[2] != 8) $display("[TB] FAIL retry_gap2: got %0d expected 8", readCyc[3] - readCyc[2]); else passes++;
        end
        checks++; if (done !== 1'b1 || error !== 1'b0) $display("[TB] FAIL retry_flags: got done=%b error=%b expected 1/0", done, error); else passes++;
        checks++; if (cfgDat.size() != 3) $display("[TB] FAIL retry_cfg_count: got %0d expected 3", cfgDat.size()); else passes++;
        if (cfgDat.size() > 0) begin
            checks++; if (cfgDat[0] !== 8'h44) $display("[TB] FAIL retry_cfg1: got %h expected 44", cfgDat[0]); else passes++;
        end
    endtask

    task automatic test_timeout_error();
        bit ok;
        clearLogs();
        mem = '{8'h2A, 8'h77, 8'h88, 8'h99};
        silentN[2] = 99;
        pulseStart();
        runUntilIdle(300, ok);
        checks++; if (!ok) $display("[TB] FAIL err_timeout: busy=%b expected 0 within budget", busy); else passes++;
        checks++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL err_flags: got error=%b busy=%b done=%b expected 1/0/0", error, busy, done); else passes++;
        checks++; if (readAddr.size() != 6) $display("[TB] FAIL err_read_count: got %0d expected 6", readAddr.size()); else passes++;
        if (readAddr.size() == 6) begin
            checks++; if (readAddr[2] != 2 || readAddr[5] != 2) $display("[TB] FAIL err_addrs: got %0d..%0d expected 2..2", readAddr[2], readAddr[5]); else passes++;
            checks++; if (readCyc[5] - readCyc[2] != 24) $display("[TB] FAIL err_span: got %0d expected 24", readCyc[5] - readCyc[2]); else passes++;
        end
        checks++; if (cfgIdx.size() != 1) $display("[TB] FAIL err_cfg_count: got %0d expected 1", cfgIdx.size()); else passes++;
        checks++; if (cfg_index !== 2'd1 || cfg_data !== 8'h77) $display("[TB] FAIL err_cfg_hold: got (%0d,%h) expected (1,77)", cfg_index, cfg_data); else passes++;
        checks++; if (ID !== 8'h2A) $display("[TB] FAIL err_id: got %h expected 2a", ID); else passes++;
        for (int i = 0; i < 20; i++) step();
        checks++; if (readAddr.size() != 6 || error !== 1'b1) $display("[TB] FAIL err_no_recover: got reads=%0d error=%b expected 6/1", readAddr.size(), error); else passes++;
    endtask

    task automatic test_blank_rescan();
        bit ok;
        int n;
        clearLogs();
        mem = '{8'h00, 8'h11, 8'h22, 8'h33};
        pulseStart();
        checks++; if (error !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL blank_start_clear: got error=%b busy=%b expected 0/1", error, busy); else passes++;
        n = 0;
        while (cfgIdx.size() < 3 && n < 100) begin
            step();
            n++;
        end
        checks++; if (cfgIdx.size() != 3) $display("[TB] FAIL blank_first_pass: got %0d cfg writes expected 3", cfgIdx.size()); else passes++;
        mem[0] = 8'h05;
        for (int i = 0; i < 5; i++) step();
        checks++; if (done !== 1'b0 || busy !== 1'b1 || error !== 1'b0) $display("[TB] FAIL blank_rescan_flags: got done=%b busy=%b error=%b expected 0/1/0", done, busy, error); else passes++;
        runUntilIdle(300, ok);
        checks++; if (!ok) $display("[TB] FAIL blank_timeout: busy=%b expected 0 within budget", busy); else passes++;
        checks++; if (readAddr.size() != 8) $display("[TB] FAIL blank_read_count: got %0d expected 8", readAddr.size()); else passes++;
        if (readAddr.size() >= 5 && cfgCyc.size() >= 3) begin
            checks++; if (readAddr[4] != 0) $display("[TB] FAIL blank_rescan_addr: got %0d expected 0", readAddr[4]); else passes++;
            checks++; if (readCyc[4] - (cfgCyc[2] + 1) != 20) $display("[TB] FAIL blank_rescan_delay: got %0d expected 20", readCyc[4] - (cfgCyc[2] + 1)); else passes++;
        end
        checks++; if (ID !== 8'h05 || done !== 1'b1) $display("[TB] FAIL blank_final: got id=%h done=%b expected 05/1", ID, done); else passes++;
    endtask

    task automatic test_late_ready_and_start();
        bit pulsed;
        int n;
        clearLogs();
        mem = '{8'h2A, 8'hAA, 8'hBB, 8'hCC};
        respDelay = 7;
        pulsed = 1'b0;
        pulseStart();
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            if (!pulsed && readCyc.size() == 2) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            step();
            start = 1'b0;
            n++;
        end
        checks++; if (busy !== 1'b0 || done !== 1'b1 || error !== 1'b0) $display("[TB] FAIL late_flags: got busy=%b done=%b error=%b expected 0/1/0", busy, done, error); else passes++;
        checks++; if (readAddr.size() != 4) $display("[TB] FAIL late_read_count: got %0d expected 4", readAddr.size()); else passes++;
        for (int i = 0; i < readAddr.size() && i < 4; i++) begin
            checks++; if (readAddr[i] != i) $display("[TB] FAIL late_addr%0d: got %0d expected %0d", i, readAddr[i], i); else passes++;
        end
        if (readCyc.size() >= 2) begin
            checks++; if (readCyc[1] - readCyc[0] != 9) $display("[TB] FAIL late_gap: got %0d expected 9", readCyc[1] - readCyc[0]); else passes++;
        end
        checks++; if (cfgDat.size() != 3) $display("[TB] FAIL late_cfg_count: got %0d expected 3", cfgDat.size()); else passes++;
        checks++; if (cfg_index !== 2'd3 || cfg_data !== 8'hCC) $display("[TB] FAIL late_cfg_last: got (%0d,%h) expected (3,cc)", cfg_index, cfg_data); else passes++;
        respDelay = 3;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        clearLogs();
        mem = '{8'h2A, 8'h11, 8'h22, 8'h33};
        respDelay = 3;
        pulseStart();
        checks++; if (eeprom_read !== 1'b1) $display("[TB] FAIL midrst_issue: got read=%b expected 1", eeprom_read); else passes++;
        step();
        reset_n = 1'b0;
        pendValid = 1'b0;
        step();
        checks++; if (eeprom_read !== 1'b0 || busy !== 1'b1 || ID !== 8'h00) $display("[TB] FAIL midrst_state: got read=%b busy=%b id=%h expected 0/1/00", eeprom_read, busy, ID); else passes++;
        reset_n = 1'b1;
        cyc = 0;
        clearLogs();
        step();
        eeprom_data_ready = 1'b1;
        eeprom_data = 8'hEE;
        step();
        step();
        checks++; if (ID !== 8'h00 || cfgIdx.size() != 0) $display("[TB] FAIL midrst_stale: got id=%h cfg_writes=%0d expected 00/0", ID, cfgIdx.size()); else passes++;
        runUntilIdle(200, ok);
        checks++; if (!ok) $display("[TB] FAIL midrst_timeout: busy=%b expected 0 within budget", busy); else passes++;
        checks++; if (readCyc.size() != 4) $display("[TB] FAIL midrst_read_count: got %0d expected 4", readCyc.size()); else passes++;
        if (readCyc.size() > 0) begin
            checks++; if (readCyc[0] != 10) $display("[TB] FAIL midrst_first_read: got %0d expected 10", readCyc[0]); else passes++;
        end
        checks++; if (ID !== 8'h2A || done !== 1'b1) $display("[TB] FAIL midrst_final: got id=%h done=%b expected 2a/1", ID, done); else passes++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        eeprom_data_ready = 1'b0;
        eeprom_data = 8'h00;
        clearLogs();
        test_reset();
        test_basic_load();
        test_retry();
        test_timeout_error();
        test_blank_rescan();
        test_late_ready_and_start();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
